// File: rtl/logphy_pkg.sv
// rtl/logphy_pkg.sv - shared constants, PRBS23 taps, lane seeds and FSM enum for the lane striper
// Seeds feed the optional LOGPHY_SCRAMBLE_EN lane scramblers.
package logphy_pkg;
   localparam int DATA_W_DEF = 128;
   localparam int LANES_DEF  = 4;
   localparam int LANE_W_DEF = 8;

   // x^23+x^21+x^16+x^8+x^5+x^2+1 as a mask over state bits [22:0] (exponent e -> bit e-1)
   localparam logic [22:0] PRBS23_TAPS = 23'h508092;

   localparam int SEED_N = 4;
   localparam logic [22:0] LFSR_SEED [SEED_N] = '{23'h7FFFFF, 23'h5A5A5A, 23'h123456, 23'h654321};

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   function automatic int calc_beats(input int data_w, input int lanes, input int lane_w);
      return data_w / (lanes * lane_w);
   endfunction
endpackage

// File: rtl/logphy_lfsr23.sv
// rtl/logphy_lfsr23.sv - per-lane PRBS23 generator, LANE_W bits per advance (LOGPHY_SCRAMBLE_EN only)
// Bit 0 of bits is the oldest generated bit; state bit 22 is shifted out first.
import logphy_pkg::*;

module logphy_lfsr23 #(
   parameter int LANE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adv_i,
   input  logic [22:0]       seed,
   output logic [LANE_W-1:0] bits
);
   logic [22:0] state;
   logic [22:0] walk;

   always_comb begin
      walk = state;
      bits = '0;
      for (int i = 0; i < LANE_W; i++) begin
         bits[i] = walk[22];
         walk    = {walk[21:0], ^(walk & PRBS23_TAPS)};
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= seed;
      else if (adv_i)
         state <= walk;
   end
endmodule

// File: rtl/logphy_lane_striper.sv
// rtl/logphy_lane_striper.sv - pops flit words and stripes them byte-wise across LANES over BEATS beats
// Define LOGPHY_SCRAMBLE_EN to XOR each lane with its own PRBS23 stream.
import logphy_pkg::*;

module logphy_lane_striper #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int LANE_W = LANE_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid_i,
   output logic                      in_rdy_o,
   input  logic [DATA_W-1:0]         data_i,
   input  logic                      tx_en_i,
   output logic                      lane_valid_o,
   output logic [LANES*LANE_W-1:0]   lane_data_o
);
   localparam int SLICE = LANES * LANE_W;
   localparam int BEATS = calc_beats(DATA_W, LANES, LANE_W);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   state_t            state;
   logic [BW-1:0]     beat;
   logic [DATA_W-1:0] rest;
   logic [SLICE-1:0]  raw;
   logic              last_beat;
   logic              consume;
   logic              accept;

   assign last_beat    = (beat == LAST);
   assign consume      = (state == ST_SEND) && tx_en_i;
   assign in_rdy_o     = !reset && ((state == ST_IDLE) || (consume && last_beat));
   assign accept       = in_valid_i && in_rdy_o;
   assign lane_valid_o = (state == ST_SEND);

   // rest holds the not-yet-shown beats, lowest beat in the bottom SLICE bits
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         beat  <= '0;
         rest  <= '0;
         raw   <= '0;
      end else if (accept) begin
         state <= ST_SEND;
         beat  <= '0;
         raw   <= data_i[SLICE-1:0];
         rest  <= data_i >> SLICE;
      end else if (consume) begin
         if (last_beat) begin
            state <= ST_IDLE;
            beat  <= '0;
            raw   <= '0;
         end else begin
            beat  <= beat + 1'b1;
            raw   <= rest[SLICE-1:0];
            rest  <= rest >> SLICE;
         end
      end
   end

`ifdef LOGPHY_SCRAMBLE_EN
   logic [SLICE-1:0] mask;
   logic             adv;

   assign adv = lane_valid_o && tx_en_i;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logphy_lfsr23 #(.LANE_W(LANE_W)) u_lfsr (
         .clk   (clk),
         .reset (reset),
         .adv_i (adv),
         .seed  (LFSR_SEED[l % SEED_N]),
         .bits  (mask[l*LANE_W +: LANE_W])
      );
   end

   // idle output stays raw zero rather than exposing the scrambler stream
   assign lane_data_o = lane_valid_o ? (raw ^ mask) : '0;
`else
   assign lane_data_o = raw;
`endif
endmodule

// File: tb/tb_logphy_lane_striper.sv
// tb/tb_logphy_lane_striper.sv - self-checking bench for logphy_lane_striper (default 128/4/8 build)
// Works with or without LOGPHY_SCRAMBLE_EN.
import logphy_pkg::*;

module tb_logphy_lane_striper;
   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_rdy;
   logic [127:0] data;
   logic         tx_en;
   logic         lane_valid;
   logic [31:0]  lane_data;

   int checks   = 0;
   int failures = 0;
   bit en_cmp   = 1'b0;

   logic [31:0] exp_q[$];
   logic [22:0] lst[4];
   logic [31:0] log_q[$];
   int          rdy_hi;

   logphy_lane_striper dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid_i   (in_valid),
      .in_rdy_o     (in_rdy),
      .data_i       (data),
      .tx_en_i      (tx_en),
      .lane_valid_o (lane_valid),
      .lane_data_o  (lane_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // PRBS23 from the polynomial exponents 23,21,16,8,5,2
   function automatic logic [22:0] prbs_step(input logic [22:0] s);
      logic fb;
      fb = s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1];
      return {s[21:0], fb};
   endfunction

   function automatic logic [7:0] prbs_byte(input logic [22:0] s);
      logic [7:0]  b;
      logic [22:0] t;
      t = s;
      for (int i = 0; i < 8; i++) begin
         b[i] = t[22];
         t    = prbs_step(t);
      end
      return b;
   endfunction

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
`ifdef LOGPHY_SCRAMBLE_EN
      for (int l = 0; l < 4; l++) m[l*8 +: 8] = prbs_byte(lst[l]);
`endif
      return m;
   endfunction

   // queue model: each accepted word becomes four 32-bit beats, one popped per consumed beat
   always @(posedge clk) begin
      bit mrdy;
      if (reset) begin
         exp_q.delete();
         for (int l = 0; l < 4; l++) lst[l] = LFSR_SEED[l];
      end else begin
         mrdy = (exp_q.size() == 0) || (exp_q.size() == 1 && tx_en);
         if (exp_q.size() > 0 && tx_en) begin
            void'(exp_q.pop_front());
            for (int l = 0; l < 4; l++)
               for (int k = 0; k < 8; k++) lst[l] = prbs_step(lst[l]);
         end
         if (in_valid && mrdy)
            for (int b = 0; b < 4; b++) exp_q.push_back(data[b*32 +: 32]);
      end
   end

   always @(negedge clk) begin
      if (en_cmp) begin
         check("in_rdy", in_rdy, !reset && ((exp_q.size() == 0) || (exp_q.size() == 1 && tx_en)));
         check("lane_valid", lane_valid, exp_q.size() > 0);
         check("lane_data", lane_data, (exp_q.size() > 0) ? (exp_q[0] ^ model_mask()) : 32'h0);
         if (lane_valid) log_q.push_back(lane_data);
         if (lane_valid && in_rdy) rdy_hi++;
      end
   end

   initial begin
      logic [127:0] w1;
      logic [127:0] w2;
      logic [15:0]  scr16;
      w1 = 128'hAABBCCDDEEFF00112233445566778899;
      w2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
`ifdef LOGPHY_SCRAMBLE_EN
      scr16 = 16'h2DFF;
`else
      scr16 = 16'h0000;
`endif
      reset = 1'b1; in_valid = 1'b1; data = w1; tx_en = 1'b1;

      // reset held two cycles with in_valid asserted
      cyc();
      en_cmp = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", lane_valid, 1'b0);
         check("rst_data", lane_data, 32'h0);
         check("rst_rdy", in_rdy, 1'b0);
         if (i == 0) cyc();
      end
      reset = 1'b0; in_valid = 1'b0;
      #1;
      check("rdy_after_reset", in_rdy, 1'b1);
      cyc();

      // single word
      log_q.delete();
      data = w1; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (6) cyc();
      check("single_count", log_q.size(), 4);
`ifndef LOGPHY_SCRAMBLE_EN
      if (log_q.size() == 4) begin
         check("single_b0", log_q[0], 32'h66778899);
         check("single_b1", log_q[1], 32'h22334455);
         check("single_b2", log_q[2], 32'hEEFF0011);
         check("single_b3", log_q[3], 32'hAABBCCDD);
      end
`endif

      // back-to-back words
      log_q.delete(); rdy_hi = 0;
      data = w1; in_valid = 1'b1;
      cyc();
      data = w2;
      repeat (4) cyc();
      in_valid = 1'b0;
      repeat (6) cyc();
      check("b2b_count", log_q.size(), 8);
      check("b2b_rdy_last_only", rdy_hi, 2);
`ifndef LOGPHY_SCRAMBLE_EN
      if (log_q.size() == 8) begin
         check("b2b_w1_b3", log_q[3], 32'hAABBCCDD);
         check("b2b_w2_b0", log_q[4], 32'hC3D2E1F0);
      end
`endif

      // stall on beat 2
      log_q.delete();
      data = w1; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc(); cyc();
      tx_en = 1'b0;
      repeat (3) begin
         cyc();
         check("stall_rdy", in_rdy, 1'b0);
      end
      tx_en = 1'b1;
      repeat (3) cyc();
      check("stall_count", log_q.size(), 7);
`ifndef LOGPHY_SCRAMBLE_EN
      if (log_q.size() == 7) begin
         check("stall_b1", log_q[1], 32'h22334455);
         for (int i = 2; i < 6; i++) check("stall_b2_hold", log_q[i], 32'hEEFF0011);
         check("stall_b3", log_q[6], 32'hAABBCCDD);
      end
`endif

      // reset mid-word
      data = w1; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("midrst_valid", lane_valid, 1'b0);
      data = w2; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("midrst_next_valid", lane_valid, 1'b1);
`ifndef LOGPHY_SCRAMBLE_EN
      check("midrst_next_b0", lane_data, 32'hC3D2E1F0);
`endif
      repeat (6) cyc();

      // all-zero word: scrambler stream from seed, stall, restart after reset
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      data = '0; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("zero_b0_l01", lane_data[15:0], scr16);
      tx_en = 1'b0;
      cyc(); cyc();
      check("zero_stall_l01", lane_data[15:0], scr16);
      tx_en = 1'b1;
      repeat (5) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("zero_restart_l01", lane_data[15:0], scr16);
      repeat (6) cyc();

      en_cmp = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
